irq_pending_latch: RTL and testbench

- Upstream request-capture stage for the 8-input priority encoder.
- Synchronises 8 asynchronous interrupt lines and detects edges or levels per channel, then holds pending bits until acknowledged.
- Drives the masked request vector straight into the encoder's h..a inputs (bit 7 = h, bit 0 = a).
- Consumes the encoder's index output as the acknowledge to clear the serviced channel.

---
 rtl/irq_pending_latch_if.sv | 29 ++
 rtl/irq_pending_latch.sv | 96 +++++++++
 tb/tb_irq_pending_latch.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/irq_pending_latch_if.sv
// Request/acknowledge bundle between the interrupt pending latch and its
// surroundings: raw lines, mask writes and encoder acknowledge in, masked
// request vector and status out.
interface irq_pending_latch_if #(
  parameter int N = 8
);
  logic [N-1:0] irq_in;
  logic         mask_we;
  logic [N-1:0] mask_wdata;
  logic         ack_valid;
  logic [2:0]   ack_idx;
  logic         overrun_clr;
  logic [N-1:0] req;
  logic         irq;
  logic [N-1:0] pending;
  logic [N-1:0] overrun;

  // Driver side: stimulus / software / encoder acknowledge.
  modport master (
    output irq_in, mask_we, mask_wdata, ack_valid, ack_idx, overrun_clr,
    input  req, irq, pending, overrun
  );

  // Latch side.
  modport slave (
    input  irq_in, mask_we, mask_wdata, ack_valid, ack_idx, overrun_clr,
    output req, irq, pending, overrun
  );
endinterface

// File: rtl/irq_pending_latch.sv
// Interrupt request capture ahead of the 8-input priority encoder.
// Each raw line is synchronised, edge- or level-detected per channel, and
// held in a pending bit until the encoder's index acknowledges it. The
// masked pending vector drives the encoder inputs directly (bit 7 = h).
module irq_pending_latch #(
  parameter int           N           = 8,
  parameter int           SYNC_STAGES = 2,      // at least 2 for metastability
  parameter logic [N-1:0] EDGE_MODE   = 8'hFF,  // 1 = rising-edge latched, 0 = level
  parameter logic [N-1:0] MASK_RESET  = 8'hFF   // 1 = masked
) (
  input  logic             clk,
  input  logic             rst_n,
  irq_pending_latch_if.slave bus
);

  logic [N-1:0] sync_q [SYNC_STAGES];
  logic [N-1:0] hist_q;
  logic [N-1:0] mask_q;
  logic [N-1:0] pending_q;
  logic [N-1:0] overrun_q;

  logic [N-1:0] sync;
  logic [N-1:0] rise;
  logic [N-1:0] ack_hit;
  logic [N-1:0] pending_d;
  logic [N-1:0] overrun_set;
  logic [N-1:0] overrun_d;
  logic [N-1:0] req_w;

  // Synchroniser chain plus one history flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this small flop array is cleared on reset on purpose: a line
      // held high through reset must look like one fresh rising edge.
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      hist_q <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the previous
      // stage's old value, which is what makes this a shift chain.
      sync_q[0] <= bus.irq_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      hist_q <= sync;
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];
  assign rise = sync & ~hist_q;

  // Decode the encoder index into a one-hot acknowledge; out-of-range
  // indices match no channel.
  always_comb begin
    // NOTE: default first so no path leaves ack_hit unassigned (no latch).
    ack_hit = '0;
    if (bus.ack_valid) begin
      for (int i = 0; i < N; i++) begin
        if (32'(bus.ack_idx) == i) ack_hit[i] = 1'b1;
      end
    end
  end

  // Edge channels: a new rise beats a coincident ack; a rise onto an already
  // pending bit (and not being acked) is an overrun. Level channels simply
  // follow the synchronised line and never overrun.
  assign pending_d   = (EDGE_MODE & ((pending_q & ~ack_hit) | rise)) |
                       (~EDGE_MODE & sync);
  assign overrun_set = EDGE_MODE & rise & pending_q & ~ack_hit;
  assign overrun_d   = (bus.overrun_clr ? '0 : overrun_q) | overrun_set;

  // Software-written mask register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= MASK_RESET;
    end else if (bus.mask_we) begin
      mask_q <= bus.mask_wdata;
    end
  end

  // Pending and sticky overrun state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      overrun_q <= '0;
    end else begin
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  // Mask only gates the request path; status readback stays unmasked.
  assign req_w       = pending_q & ~mask_q;
  assign bus.req     = req_w;
  assign bus.irq     = |req_w;
  assign bus.pending = pending_q;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_irq_pending_latch.sv
// Directed bench for irq_pending_latch: a vector table for the main
// single-cycle sequence, then hand-written sequences for level mode and
// asynchronous reset.
module tb_irq_pending_latch;

  typedef struct {
    logic [7:0] irq_in;
    logic       mask_we;
    logic [7:0] mask_wdata;
    logic       ack_valid;
    logic [2:0] ack_idx;
    logic       overrun_clr;
    logic [7:0] exp_pending;
    logic [7:0] exp_req;
    logic       exp_irq;
    logic [7:0] exp_overrun;
    int         exp_idx;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  vec_t tbl[$];

  irq_pending_latch_if #(.N(8)) bus1 ();
  irq_pending_latch_if #(.N(8)) bus2 ();

  irq_pending_latch #(
    .N(8), .SYNC_STAGES(2), .EDGE_MODE(8'hFF), .MASK_RESET(8'hFF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  irq_pending_latch #(
    .N(8), .SYNC_STAGES(2), .EDGE_MODE(8'h7F), .MASK_RESET(8'hFF)
  ) dut_lvl (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference priority encoder: index of the highest set request bit.
  function automatic int enc_idx(input logic [7:0] r);
    for (int i = 7; i >= 0; i--) if (r[i]) return i;
    return -1;
  endfunction

  task automatic add(input logic [7:0] irq_in, input logic mwe, input logic [7:0] mwd,
                     input logic av, input logic [2:0] ai, input logic oc,
                     input logic [7:0] pend, input logic [7:0] rq, input logic irq_o,
                     input logic [7:0] ovr, input int idx);
    vec_t v;
    v.irq_in = irq_in; v.mask_we = mwe; v.mask_wdata = mwd;
    v.ack_valid = av; v.ack_idx = ai; v.overrun_clr = oc;
    v.exp_pending = pend; v.exp_req = rq; v.exp_irq = irq_o;
    v.exp_overrun = ovr; v.exp_idx = idx;
    tbl.push_back(v);
  endtask

  task automatic drive1(input logic [7:0] irq_in, input logic mwe, input logic [7:0] mwd,
                        input logic av, input logic [2:0] ai, input logic oc);
    bus1.irq_in = irq_in; bus1.mask_we = mwe; bus1.mask_wdata = mwd;
    bus1.ack_valid = av; bus1.ack_idx = ai; bus1.overrun_clr = oc;
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive1(8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
    bus2.irq_in = 8'h00; bus2.mask_we = 1'b0; bus2.mask_wdata = 8'h00;
    bus2.ack_valid = 1'b0; bus2.ack_idx = 3'd0; bus2.overrun_clr = 1'b0;

    // Row k's inputs are applied, one clock edge passes, outputs are checked.
    //   irq_in mwe mwd  av ai oc   pend req irq ovr idx
    add(8'h00, 1, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0); // unmask all
    add(8'h20, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0); // pulse ch5
    add(8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0);
    add(8'h00, 0, 8'h00, 0, 0, 0, 8'h20, 8'h20, 1, 8'h00, 5); // 3rd edge
    add(8'h00, 0, 8'h00, 1, 5, 0, 8'h00, 8'h00, 0, 8'h00, 0); // ack 5
    add(8'h48, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0); // raise 6,3
    add(8'h48, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0);
    add(8'h48, 0, 8'h00, 0, 0, 0, 8'h48, 8'h48, 1, 8'h00, 6);
    add(8'h48, 0, 8'h00, 1, 6, 0, 8'h08, 8'h08, 1, 8'h00, 3); // ack 6
    add(8'h48, 0, 8'h00, 1, 3, 0, 8'h00, 8'h00, 0, 8'h00, 0); // held: no re-latch
    add(8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0);
    add(8'h04, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0); // ch2 edge 1
    add(8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0);
    add(8'h00, 0, 8'h00, 0, 0, 0, 8'h04, 8'h04, 1, 8'h00, 2);
    add(8'h04, 0, 8'h00, 0, 0, 0, 8'h04, 8'h04, 1, 8'h00, 2); // ch2 edge 2
    add(8'h00, 0, 8'h00, 0, 0, 0, 8'h04, 8'h04, 1, 8'h00, 2);
    add(8'h00, 0, 8'h00, 0, 0, 0, 8'h04, 8'h04, 1, 8'h04, 2); // overrun
    add(8'h00, 0, 8'h00, 0, 0, 1, 8'h04, 8'h04, 1, 8'h00, 2); // clear
    add(8'h04, 0, 8'h00, 0, 0, 0, 8'h04, 8'h04, 1, 8'h00, 2); // ch2 edge 3
    add(8'h00, 0, 8'h00, 0, 0, 0, 8'h04, 8'h04, 1, 8'h00, 2);
    add(8'h00, 0, 8'h00, 1, 2, 0, 8'h04, 8'h04, 1, 8'h00, 2); // rise+ack: rise wins
    add(8'h04, 0, 8'h00, 0, 0, 0, 8'h04, 8'h04, 1, 8'h00, 2); // ch2 edge 4
    add(8'h00, 0, 8'h00, 0, 0, 0, 8'h04, 8'h04, 1, 8'h00, 2);
    add(8'h00, 0, 8'h00, 0, 0, 1, 8'h04, 8'h04, 1, 8'h04, 2); // clr vs new: new wins
    add(8'h00, 0, 8'h00, 0, 0, 1, 8'h04, 8'h04, 1, 8'h00, 2);
    add(8'h00, 0, 8'h00, 1, 2, 0, 8'h00, 8'h00, 0, 8'h00, 0); // ack 2
    add(8'h00, 0, 8'h00, 1, 2, 0, 8'h00, 8'h00, 0, 8'h00, 0); // ack non-pending
    add(8'h00, 1, 8'hFF, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0); // mask all
    add(8'h01, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0); // ch0 edge
    add(8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0);
    add(8'h00, 0, 8'h00, 0, 0, 0, 8'h01, 8'h00, 0, 8'h00, 0); // masked pending
    add(8'h00, 1, 8'hFE, 0, 0, 0, 8'h01, 8'h01, 1, 8'h00, 0); // unmask ch0
    add(8'h00, 0, 8'h00, 1, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0); // ack 0

    // Reset state, sampled while rst_n is still low.
    @(negedge clk);
    @(negedge clk);
    check("reset pending", 32'(bus1.pending), 32'h00);
    check("reset req",     32'(bus1.req),     32'h00);
    check("reset irq",     32'(bus1.irq),     32'h0);
    check("reset overrun", 32'(bus1.overrun), 32'h00);
    rst_n = 1'b1;

    for (int k = 0; k < tbl.size(); k++) begin
      drive1(tbl[k].irq_in, tbl[k].mask_we, tbl[k].mask_wdata,
             tbl[k].ack_valid, tbl[k].ack_idx, tbl[k].overrun_clr);
      cycle();
      check($sformatf("row%0d pending", k), 32'(bus1.pending), 32'(tbl[k].exp_pending));
      check($sformatf("row%0d req", k),     32'(bus1.req),     32'(tbl[k].exp_req));
      check($sformatf("row%0d irq", k),     32'(bus1.irq),     32'(tbl[k].exp_irq));
      check($sformatf("row%0d overrun", k), 32'(bus1.overrun), 32'(tbl[k].exp_overrun));
      if (tbl[k].exp_irq)
        check($sformatf("row%0d enc_idx", k), 32'(enc_idx(bus1.req)), 32'(tbl[k].exp_idx));
    end
    drive1(8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);

    // Level channel 7 on the second instance.
    bus2.irq_in = 8'h80;
    cycle();
    cycle();
    check("lvl pend before latency", 32'(bus2.pending), 32'h00);
    cycle();
    check("lvl pend set", 32'(bus2.pending), 32'h80);
    bus2.ack_valid = 1'b1; bus2.ack_idx = 3'd7;
    cycle();
    check("lvl ack ignored", 32'(bus2.pending), 32'h80);
    bus2.ack_valid = 1'b0;
    cycle();
    check("lvl held", 32'(bus2.pending), 32'h80);
    check("lvl no overrun", 32'(bus2.overrun), 32'h00);
    bus2.irq_in = 8'h00;
    cycle();
    check("lvl drop +1", 32'(bus2.pending), 32'h80);
    cycle();
    check("lvl drop +2", 32'(bus2.pending), 32'h80);
    cycle();
    check("lvl cleared", 32'(bus2.pending), 32'h00);

    // Build pending = A5 with everything unmasked, then reset mid-cycle.
    drive1(8'hA5, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0);
    cycle();
    drive1(8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
    cycle();
    cycle();
    check("pre-reset pending", 32'(bus1.pending), 32'hA5);
    check("pre-reset req",     32'(bus1.req),     32'hA5);
    bus1.irq_in = 8'h02;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async rst pending", 32'(bus1.pending), 32'h00);
    check("async rst req",     32'(bus1.req),     32'h00);
    check("async rst irq",     32'(bus1.irq),     32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    cycle();
    check("post-rst before latency", 32'(bus1.pending), 32'h00);
    cycle();
    check("post-rst edge latched", 32'(bus1.pending), 32'h02);
    check("post-rst mask default", 32'(bus1.req), 32'h00);
    cycle();
    cycle();
    check("post-rst held stays", 32'(bus1.pending), 32'h02);
    bus1.ack_valid = 1'b1; bus1.ack_idx = 3'd1;
    cycle();
    bus1.ack_valid = 1'b0;
    check("post-rst ack", 32'(bus1.pending), 32'h00);
    cycle();
    cycle();
    check("post-rst single edge", 32'(bus1.pending), 32'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
